// File: rtl/bullet_slot_scheduler.sv
// Bullet slot scheduler: allocates bullets on fire, then per frame_tick walks every
// live slot doing erase -> move -> draw through a single pixel-write handshake port.
module bullet_slot_scheduler #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned COOLDOWN  = 16,
    parameter int unsigned MAX_X     = 159,
    parameter int unsigned MAX_Y     = 119
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 fire,
    input  logic [1:0]           fire_dx,
    input  logic [1:0]           fire_dy,
    input  logic [7:0]           ship_x,
    input  logic [6:0]           ship_y,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_slot,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [7:0]           pix_x,
    output logic [6:0]           pix_y,
    output logic [2:0]           pix_color,
    output logic                 fire_accept,
    output logic                 fire_reject,
    output logic [NUM_SLOTS-1:0] active_mask,
    output logic                 scan_done
);

    localparam int unsigned CW = $clog2(COOLDOWN + 1);

    typedef enum logic [2:0] {StIdle, StScan, StErase, StMove, StDraw} state_e;

    state_e               state;
    logic [2:0]           ptr;
    logic [CW-1:0]        cooldown;
    logic [NUM_SLOTS-1:0] fresh;
    logic [7:0]           slot_x  [NUM_SLOTS];
    logic [6:0]           slot_y  [NUM_SLOTS];
    logic [1:0]           slot_dx [NUM_SLOTS];
    logic [1:0]           slot_dy [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] hit_mask;
    logic [NUM_SLOTS-1:0] free_mask;
    logic                 free_any;
    logic [2:0]           free_idx;
    logic                 dir_ok;
    logic                 pos_ok;
    logic                 can_fire;
    logic                 cur_live;
    logic                 last_slot;
    logic                 move_off;
    logic [7:0]           next_x;
    logic [6:0]           next_y;

    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    always_comb begin
        hit_mask  = hit_valid ? (NUM_SLOTS'(1) << hit_slot) : '0;
        // A slot being hit this edge is not handed out to a simultaneous fire
        free_mask = ~active_mask & ~hit_mask;
        free_any  = 1'b0;
        free_idx  = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end
        dir_ok    = (fire_dx == 2'b01) || (fire_dx == 2'b10) ||
                    (fire_dy == 2'b01) || (fire_dy == 2'b10);
        pos_ok    = (32'(ship_x) <= MAX_X) && (32'(ship_y) <= MAX_Y);
        can_fire  = fire && (cooldown == '0) && free_any && pos_ok && dir_ok;
        cur_live  = active_mask[ptr] && !hit_mask[ptr];
        last_slot = (ptr == 3'(NUM_SLOTS - 1));
    end

    always_comb begin
        next_x   = slot_x[ptr];
        next_y   = slot_y[ptr];
        move_off = 1'b0;
        case (slot_dx[ptr])
            2'b01:   if (32'(slot_x[ptr]) >= MAX_X) move_off = 1'b1;
                     else next_x = slot_x[ptr] + 8'd1;
            2'b10:   if (slot_x[ptr] == 8'd0) move_off = 1'b1;
                     else next_x = slot_x[ptr] - 8'd1;
            default: ;
        endcase
        case (slot_dy[ptr])
            2'b01:   if (32'(slot_y[ptr]) >= MAX_Y) move_off = 1'b1;
                     else next_y = slot_y[ptr] + 7'd1;
            2'b10:   if (slot_y[ptr] == 7'd0) move_off = 1'b1;
                     else next_y = slot_y[ptr] - 7'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            ptr         <= 3'd0;
            cooldown    <= '0;
            fresh       <= '0;
            active_mask <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= 8'd0;
            pix_y       <= 7'd0;
            pix_color   <= 3'd0;
            fire_accept <= 1'b0;
            fire_reject <= 1'b0;
            scan_done   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x[i]  <= 8'd0;
                slot_y[i]  <= 7'd0;
                slot_dx[i] <= 2'd0;
                slot_dy[i] <= 2'd0;
            end
        end else begin
            fire_accept <= can_fire;
            fire_reject <= fire && !can_fire;
            scan_done   <= 1'b0;
            // Loading COOLDOWN-1 makes the next accept land exactly COOLDOWN cycles later
            if (can_fire)              cooldown <= CW'(COOLDOWN - 1);
            else if (cooldown != '0)   cooldown <= cooldown - 1'b1;

            case (state)
                StIdle: begin
                    if (frame_tick) begin
                        fresh <= '0;
                        ptr   <= 3'd0;
                        state <= StScan;
                    end
                end
                StScan: begin
                    if (cur_live && !fresh[ptr]) begin
                        pix_valid <= 1'b1;
                        pix_x     <= slot_x[ptr];
                        pix_y     <= slot_y[ptr];
                        pix_color <= 3'b000;
                        state     <= StErase;
                    end else if (last_slot) begin
                        scan_done <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        ptr <= ptr + 3'd1;
                    end
                end
                StErase: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        state     <= StMove;
                    end
                end
                StMove: begin
                    if (cur_live && !move_off) begin
                        slot_x[ptr] <= next_x;
                        slot_y[ptr] <= next_y;
                        pix_valid   <= 1'b1;
                        pix_x       <= next_x;
                        pix_y       <= next_y;
                        pix_color   <= 3'b111;
                        state       <= StDraw;
                    end else begin
                        active_mask[ptr] <= 1'b0;
                        if (last_slot) begin
                            scan_done <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            ptr   <= ptr + 3'd1;
                            state <= StScan;
                        end
                    end
                end
                StDraw: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last_slot) begin
                            scan_done <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            ptr   <= ptr + 3'd1;
                            state <= StScan;
                        end
                    end
                end
                default: state <= StIdle;
            endcase

            if (can_fire) begin
                active_mask[free_idx] <= 1'b1;
                fresh[free_idx]       <= 1'b1;
                slot_x[free_idx]      <= ship_x;
                slot_y[free_idx]      <= ship_y;
                slot_dx[free_idx]     <= norm_dir(fire_dx);
                slot_dy[free_idx]     <= norm_dir(fire_dy);
            end
            if (hit_valid) active_mask[hit_slot] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Directed self-checking bench for bullet_slot_scheduler: fire rules, one scan pass,
// edge kills, handshake stalls, hit/fire interaction and reset mid-draw.
module tb_bullet_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset, frame_tick, fire, hit_valid, pix_ready;
    logic [1:0] fire_dx, fire_dy;
    logic [7:0] ship_x;
    logic [6:0] ship_y;
    logic [2:0] hit_slot;
    logic       pix_valid, fire_accept, fire_reject, scan_done;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_color;
    logic [7:0] active_mask;

    bullet_slot_scheduler dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
        .fire_dx(fire_dx), .fire_dy(fire_dy), .ship_x(ship_x), .ship_y(ship_y),
        .hit_valid(hit_valid), .hit_slot(hit_slot), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .fire_accept(fire_accept), .fire_reject(fire_reject),
        .active_mask(active_mask), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_rej    = 0;
    int          n_done   = 0;
    logic [17:0] pix_log [$];
    int          acc_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Completed handshakes and result pulses, seen mid-cycle
    always @(negedge clk) begin
        if (pix_valid && pix_ready) pix_log.push_back({pix_x, pix_y, pix_color});
        if (fire_accept) acc_cyc.push_back(cyc);
        if (fire_reject) n_rej++;
        if (scan_done)   n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] px(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fire = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0; pix_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        pix_log.delete(); acc_cyc.delete(); n_rej = 0; n_done = 0;
    endtask

    task automatic fire_once(input int x, input int y, input logic [1:0] dx,
                             input logic [1:0] dy);
        ship_x = 8'(x); ship_y = 7'(y); fire_dx = dx; fire_dy = dy; fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_scan(input int max);
        int start = n_done;
        int k = 0;
        while (n_done == start && k < max) begin step(); k++; end
        check("scan_done_seen", 32'(n_done > start), 1);
    endtask

    task automatic wait_pix(input int max);
        int k = 0;
        while (!pix_valid && k < max) begin step(); k++; end
        check("pix_valid_seen", 32'(pix_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with a valid fire pending: reset must win
        reset = 1'b1; frame_tick = 1'b0; hit_valid = 1'b0; hit_slot = 3'd0; pix_ready = 1'b1;
        ship_x = 8'd80; ship_y = 7'd60; fire_dx = 2'b01; fire_dy = 2'b00; fire = 1'b1;
        step(); step();
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_xyc", 32'({pix_x, pix_y, pix_color}), 0);
        check("rst_fire_pulses", 32'({fire_accept, fire_reject}), 0);
        check("rst_active_mask", 32'(active_mask), 0);
        check("rst_scan_done", 32'(scan_done), 0);
        do_reset();

        // Fire qualification boundaries
        fire_once(160, 10, 2'b01, 2'b00);
        check("rej_x_160", 32'({fire_accept, fire_reject}), 32'b01);
        fire_once(10, 120, 2'b01, 2'b00);
        check("rej_y_120", 32'({fire_accept, fire_reject}), 32'b01);
        fire_once(10, 10, 2'b11, 2'b11);
        check("rej_dir_11", 32'({fire_accept, fire_reject}), 32'b01);
        fire_once(10, 10, 2'b00, 2'b00);
        check("rej_dir_00", 32'({fire_accept, fire_reject}), 32'b01);
        fire_once(159, 119, 2'b10, 2'b00);
        check("acc_corner", 32'({fire_accept, fire_reject}), 32'b10);
        fire_once(10, 10, 2'b01, 2'b00);
        check("rej_cooldown", 32'({fire_accept, fire_reject}), 32'b01);

        // Basic pass: erase old position, draw stepped one
        do_reset();
        pix_ready = 1'b1;
        fire_once(80, 60, 2'b01, 2'b00);
        check("basic_accept", 32'(fire_accept), 1);
        check("basic_mask_after_fire", 32'(active_mask), 32'h01);
        tick();
        wait_scan(40);
        check("basic_pix_count", 32'(pix_log.size()), 2);
        if (pix_log.size() >= 2) begin
            check("basic_erase", 32'(pix_log[0]), 32'(px(80, 60, 0)));
            check("basic_draw", 32'(pix_log[1]), 32'(px(81, 60, 7)));
        end
        check("basic_mask", 32'(active_mask), 32'h01);

        // Right-edge bullet is erased and retired without a draw
        do_reset();
        pix_ready = 1'b1;
        fire_once(159, 30, 2'b01, 2'b00);
        tick();
        wait_scan(40);
        check("edge_pix_count", 32'(pix_log.size()), 1);
        if (pix_log.size() >= 1) check("edge_erase", 32'(pix_log[0]), 32'(px(159, 30, 0)));
        check("edge_mask", 32'(active_mask), 0);

        // Stalled erase holds its pixel
        do_reset();
        fire_once(10, 20, 2'b10, 2'b01);
        tick();
        wait_pix(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 32'({pix_valid, pix_x, pix_y, pix_color}),
                  32'({1'b1, px(10, 20, 0)}));
            step();
        end
        pix_ready = 1'b1;
        wait_scan(40);
        check("stall_pix_count", 32'(pix_log.size()), 2);
        if (pix_log.size() >= 2) begin
            check("stall_erase", 32'(pix_log[0]), 32'(px(10, 20, 0)));
            check("stall_draw", 32'(pix_log[1]), 32'(px(9, 21, 7)));
        end

        // Hit slot 2 during its pending erase, with a simultaneous fire
        do_reset();
        fire_once(50, 50, 2'b01, 2'b00);
        repeat (20) step();
        fire_once(60, 60, 2'b01, 2'b00);
        repeat (20) step();
        fire_once(70, 70, 2'b00, 2'b10);
        repeat (20) step();
        check("hit_mask_setup", 32'(active_mask), 32'h07);
        pix_ready = 1'b0;
        tick();
        for (int k = 0; k < 60; k++) begin
            if (pix_valid && pix_x == 8'd70) break;
            if (pix_valid) begin
                pix_ready = 1'b1; step(); pix_ready = 1'b0;
            end else begin
                step();
            end
        end
        check("hit_erase_pending", 32'({pix_valid, pix_x, pix_y, pix_color}),
              32'({1'b1, px(70, 70, 0)}));
        hit_valid = 1'b1; hit_slot = 3'd2;
        ship_x = 8'd30; ship_y = 7'd30; fire_dx = 2'b01; fire_dy = 2'b00; fire = 1'b1;
        step();
        hit_valid = 1'b0; fire = 1'b0;
        check("hit_fire_accept", 32'(fire_accept), 1);
        check("hit_mask_after", 32'(active_mask), 32'h0B);
        check("hit_erase_held", 32'({pix_valid, pix_x, pix_y, pix_color}),
              32'({1'b1, px(70, 70, 0)}));
        pix_ready = 1'b1;
        wait_scan(40);
        check("hit_pix_count", 32'(pix_log.size()), 5);
        if (pix_log.size() >= 5) begin
            check("hit_slot1_draw", 32'(pix_log[3]), 32'(px(61, 60, 7)));
            check("hit_slot2_erase", 32'(pix_log[4]), 32'(px(70, 70, 0)));
        end
        check("hit_mask_end", 32'(active_mask), 32'h0B);

        // Reset while a draw is stalled
        do_reset();
        fire_once(40, 40, 2'b01, 2'b00);
        tick();
        wait_pix(20);
        pix_ready = 1'b1; step(); pix_ready = 1'b0;
        wait_pix(20);
        check("rstdraw_pending", 32'({pix_valid, pix_x, pix_y, pix_color}),
              32'({1'b1, px(41, 40, 7)}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstdraw_pix_valid", 32'(pix_valid), 0);
        check("rstdraw_mask", 32'(active_mask), 0);
        pix_ready = 1'b1;
        tick();
        wait_scan(20);
        check("rstdraw_no_pixel", 32'(pix_log.size()), 1);

        // Continuous fire: cooldown spacing and slot exhaustion
        do_reset();
        pix_ready = 1'b1;
        ship_x = 8'd100; ship_y = 7'd100; fire_dx = 2'b01; fire_dy = 2'b00; fire = 1'b1;
        repeat (200) step();
        fire = 1'b0;
        step(); step();
        check("burst_accepts", 32'(acc_cyc.size()), 8);
        check("burst_rejects", 32'(n_rej), 192);
        for (int i = 0; i < 7 && i + 1 < acc_cyc.size(); i++)
            check("burst_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 16);
        check("burst_mask", 32'(active_mask), 32'hFF);
        fire_once(100, 100, 2'b01, 2'b00);
        check("full_reject", 32'({fire_accept, fire_reject}), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
